// File: rtl/pad_stream_ctrl.sv
// Streams a SIZE x SIZE map as a zero-padded P x P raster. Interior positions are read
// from the buffer and border positions become zeros; all elements share one pipeline.
module pad_stream_ctrl #(
  parameter int SIZE = 5,
  parameter int PAD  = 1,
  parameter int DW   = 32,
  parameter int AW   = $clog2(SIZE*SIZE),
  parameter int CW   = $clog2(SIZE+2*PAD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          out_last
);
  localparam int P = SIZE + 2*PAD;
  localparam logic [CW-1:0] PMAX = CW'(P-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          last;
  } elem_t;

  state_t        state, state_n;
  logic [CW-1:0] r, c;
  logic          issued_all;
  logic          inf_vld, inf_pad, inf_last;
  logic [CW-1:0] inf_row, inf_col;
  elem_t         fifo [2];
  elem_t         head;
  logic          rp, wp;
  logic [1:0]    cnt;
  logic [AW-1:0] addr_q, addr_n;
  logic          pop, issue, interior, at_end;
  int            ri, ci;

  assign head      = fifo[rp];
  assign out_valid = cnt != 2'd0;
  assign out_data  = head.data;
  assign out_row   = head.row;
  assign out_col   = head.col;
  assign out_last  = out_valid && head.last;
  assign pop       = out_valid && out_ready;
  assign busy      = state != S_IDLE;
  assign done      = state == S_DONE;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN:   if (pop && out_last) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Credit: buffered + in-flight + this issue, less this cycle's pop, must fit the 2-entry FIFO.
  always_comb begin
    ri          = 32'(r);
    ci          = 32'(c);
    interior    = (ri >= PAD) && (ri < PAD+SIZE) && (ci >= PAD) && (ci < PAD+SIZE);
    addr_n      = AW'((ri-PAD)*SIZE + (ci-PAD));
    at_end      = (r == PMAX) && (c == PMAX);
    issue       = (state == S_RUN) && !issued_all &&
                  (({1'b0, cnt} + {2'b0, inf_vld} + 3'd1 - {2'b0, pop}) <= 3'd2);
    mem_rd_en   = issue && interior;
    mem_rd_addr = mem_rd_en ? addr_n : addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r          <= '0;
      c          <= '0;
      issued_all <= 1'b0;
      addr_q     <= '0;
      inf_vld    <= 1'b0;
      inf_pad    <= 1'b0;
      inf_last   <= 1'b0;
      inf_row    <= '0;
      inf_col    <= '0;
      fifo[0]    <= '0;
      fifo[1]    <= '0;
      rp         <= 1'b0;
      wp         <= 1'b0;
      cnt        <= 2'd0;
    end else begin
      if (state == S_IDLE && start) begin
        r          <= '0;
        c          <= '0;
        issued_all <= 1'b0;
      end else if (issue) begin
        if (at_end)             issued_all <= 1'b1;
        else if (c == PMAX) begin
          c <= '0;
          r <= r + 1'b1;
        end else                c <= c + 1'b1;
      end
      if (mem_rd_en) addr_q <= addr_n;
      inf_vld <= issue;
      if (issue) begin
        inf_pad  <= !interior;
        inf_last <= at_end;
        inf_row  <= r;
        inf_col  <= c;
      end
      // Read data is valid during the in-flight cycle and lands in the FIFO at its end.
      if (inf_vld) begin
        fifo[wp] <= '{data: inf_pad ? {DW{1'b0}} : mem_rd_data,
                      row: inf_row, col: inf_col, last: inf_last};
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, inf_vld} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_pad_stream_ctrl.sv
// Bench for pad_stream_ctrl: a 3x3/PAD=1 instance and a 2x2/PAD=0 instance, checked
// against a raster model of the padded map plus hand-computed expectations.
module tb_pad_stream_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, ready_a = 1'b1;

  logic        a_busy, a_done, a_rd_en, a_valid, a_last;
  logic [3:0]  a_addr;
  logic [31:0] a_rdata, a_data;
  logic [2:0]  a_row, a_col;

  logic        b_busy, b_done, b_rd_en, b_valid, b_last;
  logic [1:0]  b_addr;
  logic [31:0] b_rdata, b_data;
  logic [0:0]  b_row, b_col;

  pad_stream_ctrl #(.SIZE(3), .PAD(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(a_busy), .done(a_done),
    .mem_rd_en(a_rd_en), .mem_rd_addr(a_addr), .mem_rd_data(a_rdata),
    .out_valid(a_valid), .out_ready(ready_a), .out_data(a_data),
    .out_row(a_row), .out_col(a_col), .out_last(a_last));

  pad_stream_ctrl #(.SIZE(2), .PAD(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(b_busy), .done(b_done),
    .mem_rd_en(b_rd_en), .mem_rd_addr(b_addr), .mem_rd_data(b_rdata),
    .out_valid(b_valid), .out_ready(1'b1), .out_data(b_data),
    .out_row(b_row), .out_col(b_col), .out_last(b_last));

  always #5 clk = ~clk;

  // Buffer contents mem[a] = a+1; garbage when not reading so pad zeros must be injected.
  always @(posedge clk) begin
    a_rdata <= a_rd_en ? 32'(a_addr) + 32'd1 : 32'hDEADBEEF;
    b_rdata <= b_rd_en ? 32'(b_addr) + 32'd1 : 32'hDEADBEEF;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0, tot_cnt = 0;
  task automatic check(input bit ok, input string name, input longint act, input longint req);
    tot_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  typedef struct {int data; int row; int col; bit last;} el_t;
  el_t expa[$], expb[$];
  int  rda[$], rdb[$];

  task automatic build(input bit b);
    int s, pd, p;
    el_t e;
    s = b ? 2 : 3;
    pd = b ? 0 : 1;
    p = s + 2*pd;
    if (b) begin expb.delete(); rdb.delete(); end
    else   begin expa.delete(); rda.delete(); end
    for (int i = 0; i < p*p; i++) begin
      int rr, cc;
      bit in_map;
      rr = i / p;
      cc = i % p;
      in_map = rr >= pd && rr < pd+s && cc >= pd && cc < pd+s;
      e.row = rr;
      e.col = cc;
      e.last = (i == p*p-1);
      e.data = in_map ? (rr-pd)*s + (cc-pd) + 1 : 0;
      if (b) begin
        expb.push_back(e);
        if (in_map) rdb.push_back((rr-pd)*s + (cc-pd));
      end else begin
        expa.push_back(e);
        if (in_map) rda.push_back((rr-pd)*s + (cc-pd));
      end
    end
  endtask

  int t0 = 0, nxa = 0, xfirst = 0, xlast = 0, ndone = 0, done_rel = 0, nrd_a = 0;
  int nxb = 0, ndone_b = 0;
  int got_a [25];
  int got_b [4];
  int rmode = 0, rph = 0;

  initial forever begin
    @(posedge clk); #1;
    rph++;
    case (rmode)
      0:       ready_a = 1'b1;
      1:       ready_a = (rph % 4 == 0) || (rph % 4 == 3);
      default: ready_a = 1'b0;
    endcase
  end

  // Compare process: every cycle, outputs of both instances against the model.
  initial begin
    int rel, ea;
    bit have, ok, pv;
    el_t e;
    logic [31:0] p_data;
    logic [2:0]  p_row, p_col;
    logic        p_last;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 1'b0;
      end else begin
        rel = cyc - t0 + 1;
        if (a_rd_en) begin
          ea = rda.size() > 0 ? rda[0] : -1;
          if (rda.size() > 0) void'(rda.pop_front());
          check(32'(a_addr) == ea, "a_rd_addr", a_addr, ea);
          nrd_a++;
        end
        if (pv)
          check(a_valid && a_data == p_data && a_row == p_row && a_col == p_col &&
                a_last == p_last, "a_stable", a_data, p_data);
        if (a_valid && ready_a) begin
          have = expa.size() > 0;
          if (have) e = expa.pop_front();
          else      e = '{-1, -1, -1, 1'b0};
          ok = have && a_data == 32'(e.data) && 32'(a_row) == e.row &&
               32'(a_col) == e.col && a_last == e.last;
          check(ok, $sformatf("a_elem(%0d,%0d)", e.row, e.col), a_data, e.data);
          if (nxa < 25) got_a[nxa] = 32'(a_data);
          if (nxa == 0) xfirst = rel;
          xlast = rel;
          nxa++;
        end
        if (a_done) begin ndone++; done_rel = rel; end
        pv = a_valid && !ready_a;
        p_data = a_data; p_row = a_row; p_col = a_col; p_last = a_last;

        if (b_rd_en) begin
          ea = rdb.size() > 0 ? rdb[0] : -1;
          if (rdb.size() > 0) void'(rdb.pop_front());
          check(32'(b_addr) == ea, "b_rd_addr", b_addr, ea);
        end
        if (b_valid) begin
          have = expb.size() > 0;
          if (have) e = expb.pop_front();
          else      e = '{-1, -1, -1, 1'b0};
          ok = have && b_data == 32'(e.data) && 32'(b_row) == e.row &&
               32'(b_col) == e.col && b_last == e.last;
          check(ok, $sformatf("b_elem(%0d,%0d)", e.row, e.col), b_data, e.data);
          if (nxb < 4) got_b[nxb] = 32'(b_data);
          nxb++;
        end
        if (b_done) ndone_b++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_a_run(input int mode);
    build(1'b0);
    nxa = 0; ndone = 0; nrd_a = 0; rmode = mode;
    @(posedge clk); #1;
    start_a = 1'b1;
    t0 = cyc + 1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_a(input int budget, input bit repulse);
    int k;
    k = 0;
    while (ndone == 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
      start_a = repulse && (k == 5 || a_done);
    end
    start_a = 1'b0;
    check(ndone != 0, "a_done_timeout", k, budget);
  endtask

  initial begin
    tick(3);
    check({a_busy, a_done, a_rd_en, a_valid, a_last} == 5'b0, "reset_flags",
          {a_busy, a_done, a_rd_en, a_valid, a_last}, 0);
    check(a_addr == 0 && a_data == 0 && a_row == 0 && a_col == 0, "reset_values", a_data, 0);
    reset = 1'b0;
    tick(2);

    // Full-rate stream
    start_a_run(0);
    wait_a(60, 1'b0);
    tick(2);
    check(nxa == 25, "t1_xfers", nxa, 25);
    check(xfirst == 3, "t1_first_cycle", xfirst, 3);
    check(xlast == 27, "t1_last_cycle", xlast, 27);
    check(done_rel == 28, "t1_done_cycle", done_rel, 28);
    check(ndone == 1, "t1_done_count", ndone, 1);
    check(nrd_a == 9, "t1_reads", nrd_a, 9);
    check(!a_busy, "t1_busy_low", a_busy, 0);
    check(got_a[6] == 1, "t1_r1c1", got_a[6], 1);
    check(got_a[8] == 3, "t1_r1c3", got_a[8], 3);
    check(got_a[12] == 5, "t1_r2c2", got_a[12], 5);
    check(got_a[18] == 9, "t1_r3c3", got_a[18], 9);
    check(got_a[20] == 0, "t1_r4c0", got_a[20], 0);
    check(got_a[4] == 0, "t1_r0c4", got_a[4], 0);
    check(expa.size() == 0 && rda.size() == 0, "t1_model_drained", expa.size(), 0);

    // Ready toggling 1,0,0,1
    start_a_run(1);
    wait_a(200, 1'b0);
    rmode = 0;
    tick(2);
    check(nxa == 25, "t2_xfers", nxa, 25);
    check(ndone == 1, "t2_done_count", ndone, 1);
    check(expa.size() == 0, "t2_model_drained", expa.size(), 0);

    // Long stall then release
    start_a_run(2);
    tick(20);
    check(nrd_a <= 1, "t3_reads_stalled", nrd_a, 1);
    check(nxa == 0, "t3_no_xfer", nxa, 0);
    check(a_valid && a_row == 0 && a_col == 0, "t3_head_r0c0", {a_row, a_col}, 0);
    rmode = 0;
    wait_a(60, 1'b0);
    tick(2);
    check(nxa == 25, "t3_xfers", nxa, 25);
    check(nrd_a == 9, "t3_reads", nrd_a, 9);

    // Reset in cycle 10 of a run
    start_a_run(0);
    tick(9);
    reset = 1'b1;
    expa.delete();
    rda.delete();
    tick(1);
    reset = 1'b0;
    check({a_busy, a_done, a_rd_en, a_valid, a_last} == 5'b0, "t4_flags_cleared",
          {a_busy, a_done, a_rd_en, a_valid, a_last}, 0);
    check(a_addr == 0 && a_data == 0 && a_row == 0 && a_col == 0, "t4_values_cleared",
          a_data, 0);
    tick(10);
    check(ndone == 0, "t4_no_done", ndone, 0);
    start_a_run(0);
    wait_a(60, 1'b0);
    tick(2);
    check(nxa == 25, "t4_rerun_xfers", nxa, 25);
    check(expa.size() == 0, "t4_model_drained", expa.size(), 0);

    // start re-pulsed while busy and in the DONE cycle
    start_a_run(0);
    wait_a(60, 1'b1);
    tick(30);
    check(nxa == 25, "t5_xfers", nxa, 25);
    check(ndone == 1, "t5_done_count", ndone, 1);
    check(!a_busy, "t5_idle", a_busy, 0);

    // 2x2 map without padding
    build(1'b1);
    nxb = 0; ndone_b = 0;
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int k = 0; k < 30 && ndone_b == 0; k++) tick(1);
    tick(2);
    check(ndone_b == 1, "b_done", ndone_b, 1);
    check(nxb == 4, "b_xfers", nxb, 4);
    check(got_b[0] == 1 && got_b[3] == 4, "b_data_ends", got_b[3], 4);
    check(expb.size() == 0 && rdb.size() == 0, "b_model_drained", expb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/pad_stream_ctrl.md
Name: pad_stream_ctrl

Overview:
- Sequencer that streams a SIZE x SIZE feature map out of a single-port read buffer as a zero-padded (SIZE+2*PAD) x (SIZE+2*PAD) raster for the convolution engine.
- Replaces whole-array padding with per-element streaming.
- Issues buffer reads only for interior positions and injects zeros for border positions.
- Has a start/done handshake toward the layer scheduler and a valid/ready stream toward the conv datapath.

Parameters:
- SIZE, 5, input map width and height.
- PAD, 1, zero border width on every side; 0 is legal (pass-through).
- DW, 32, element width.
- AW, $clog2(SIZE*SIZE), buffer address width (derived).
- CW, $clog2(SIZE+2*PAD), out_row/out_col width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to stream one map.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last element is consumed.
- mem_rd_en  out  1  buffer read strobe.
- mem_rd_addr  out  AW  row-major address.
- mem_rd_data  in  DW  read data, valid exactly 1 cycle after mem_rd_en.
- out_valid  out  1  stream element valid.
- out_ready  in  1  downstream accept.
- out_data  out  DW  element value.
- out_row  out  CW  padded row index.
- out_col  out  CW  padded column index.
- out_last  out  1  high on element (P-1,P-1).

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high.
- Definitions: P = SIZE+2*PAD. Transfer = out_valid && out_ready.
- Reset: state IDLE. busy, done, mem_rd_en, out_valid, out_last = 0. mem_rd_addr, out_data, out_row, out_col = 0. Position counters, in-flight flag and skid buffer are cleared.
- Reset mid-operation: aborts immediately. A pending read's data is discarded. No done pulse.
- FSM IDLE -> RUN: on start. start is ignored while busy.
- FSM RUN -> DONE: on transfer of the out_last element.
- FSM DONE -> IDLE: unconditionally next cycle. done = 1 only in DONE. busy = 1 in RUN and DONE.
- Issue counter (r,c): raster order, c fastest, starts (0,0) on entry to RUN, stops after (P-1,P-1) is issued.
- Interior position (PAD <= r,c < PAD+SIZE): mem_rd_en = 1, mem_rd_addr = (r-PAD)*SIZE + (c-PAD).
- Border position: mem_rd_en = 0, address held. The element is still issued through the same pipeline so order and latency are uniform.
- Pipeline:
  - issue cycle.
  - in-flight cycle: (r, c, pad flag) held; mem_rd_data sampled at the end of this cycle.
  - element written into a 2-entry output FIFO; the head drives out_*.
  - out_data = pad ? 0 : captured mem_rd_data.
- Credit rule: issue is permitted in a cycle only if (FIFO occupancy + in-flight + 1 - pop_this_cycle) <= 2. With out_ready held high, throughput is 1 element/cycle. The FIFO never overflows.
- Latency: start sampled at edge 0; first issue in cycle 1; first out_valid in cycle 3.
- Stream rules: out_valid, once high, holds with all out_* stable until transfer. No bubbles are inserted while credit is available.
- out_last = 1 only on the (P-1,P-1) element.
- PAD = 0: every position is a read; behaves as a plain read streamer.
- Simultaneous start and reset: reset wins.
- start in the DONE cycle: ignored.

Test Plan:
- SIZE=3, PAD=1, mem[a]=a+1, out_ready=1, start pulse:
  - exactly 25 transfers in consecutive cycles 3..27.
  - rows 0 and 4 and columns 0 and 4 have data 0.
  - interior rows read 0,1,2,3,0 / 0,4,5,6,0 / 0,7,8,9,0.
  - 9 reads at addresses 0..8 in order.
  - out_last on transfer 25; done pulse one cycle later; busy low after.
- Same setup, out_ready toggling 1,0,0,1 repeating:
  - same 25-element sequence, no loss or duplication.
  - out_* stable while stalled.
  - never more than 2 elements buffered plus 1 in flight.
- out_ready=0 for 20 cycles after start:
  - issue stops after 2 elements.
  - mem_rd_en is asserted at most once, because (0,0) and (0,1) are both border positions.
  - release produces correct ordering.
- Reset asserted in cycle 10 of a run:
  - all outputs 0 next cycle, no done.
  - a new start then yields a full correct 25-element map.
- start re-pulsed while busy and in the DONE cycle: ignored; exactly one map streamed.
- SIZE=2, PAD=0: 4 transfers with data mem[0..3], addresses 0,1,2,3, out_last on the 4th.
